// File: rtl/rv32_muldiv_pkg.sv
// rv32_muldiv_pkg: opcode/state enums and operand-class helpers for the RV32M multiply/divide unit
package rv32_muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} muldiv_state_e;

  function automatic logic is_signed_rs1(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_rs2(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/rv32_muldiv_step.sv
// rv32_muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module rv32_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum, rem_sh, diff;
  // acc holds {high, low}: product/multiplier for multiply, remainder/quotient for divide
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff   = rem_sh - {1'b0, b_i};
    acc_o  = !div_i ? {sum, acc_i[XLEN-1:1]}
           : diff[XLEN] ? {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0}
           : {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
  end
endmodule

// File: rtl/rv32_muldiv_unit.sv
// rv32_muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake and kill
module rv32_muldiv_unit
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d, op_n;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d, mag1, mag2, fix_res, spec_res;
  logic [4:0]        tag_q, tag_d, rd_q, rd_d;
  logic              neg_q, neg_d, negr_q, negr_d;
  logic              s1, s2, dz, ovf, early, accept, div_mode;

  assign div_mode = is_div(op_q);

  rv32_muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i(div_mode),
    .acc_i(acc_q),
    .b_i  (b_q),
    .acc_o(acc_step)
  );

  // operand conditioning, sign fix-up and FSM next state; neg_q is cleared on divide-by-zero so the quotient stays all-ones
  always_comb begin
    op_n     = muldiv_op_e'(op);
    s1       = is_signed_rs1(op_n) & rs1[XLEN-1];
    s2       = is_signed_rs2(op_n) & rs2[XLEN-1];
    mag1     = s1 ? -rs1 : rs1;
    mag2     = s2 ? -rs2 : rs2;
    dz       = rs2 == '0;
    ovf      = is_signed_rs2(op_n) && rs1 == MIN_V && rs2 == '1;
    early    = EARLY_OUT && is_div(op_n) && (dz || ovf);
    spec_res = dz ? (op[1] ? rs1 : '1) : (op[1] ? '0 : MIN_V);
    prod     = neg_q ? -acc_q : acc_q;
    fix_res  = op_q inside {OP_REM, OP_REMU} ? (negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN])
             : is_div(op_q) ? (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0])
             : op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    accept   = (state_q == S_IDLE || state_q == S_DONE) && start && !kill;
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    tag_d    = tag_q;
    res_d    = res_q;
    rd_d     = rd_q;
    if (kill) begin
      state_d = S_IDLE;
    end else if (accept) begin
      op_d    = op_n;
      tag_d   = rd_in;
      acc_d   = {{XLEN{1'b0}}, mag1};
      b_d     = mag2;
      cnt_d   = CW'(XLEN);
      neg_d   = (s1 ^ s2) && !(is_div(op_n) && dz);
      negr_d  = s1;
      state_d = early ? S_DONE : S_CALC;
      res_d   = early ? spec_res : res_q;
      rd_d    = early ? rd_in : rd_q;
    end else if (state_q == S_CALC) begin
      acc_d   = acc_step;
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? S_FIX : S_CALC;
    end else if (state_q == S_FIX) begin
      res_d   = fix_res;
      rd_d    = tag_q;
      state_d = S_DONE;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  assign busy   = state_q inside {S_CALC, S_FIX};
  assign done   = state_q == S_DONE;
  assign result = res_q;
  assign rd_out = rd_q;
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// tb_rv32_muldiv_unit: randomized and directed checks of two unit instances (EARLY_OUT 0 and 1) against an arithmetic model
module tb_rv32_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        busy_w[2], done_w[2];
  logic [31:0] res_w[2];
  logic [4:0]  rd_w[2];
  int          checks = 0, failures = 0;
  bit          act[2];
  int          left[2];
  logic [31:0] pend_r[2], out_r[2];
  logic [4:0]  pend_d[2], out_d[2];

  always #5 clk = ~clk;

  rv32_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .rd_out(rd_w[0])
  );

  rv32_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .rd_out(rd_w[1])
  );

  function automatic logic [31:0] ref_fn(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return pu[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: return b == 0 ? 32'hffffffff : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hffffffff : a / b;
      3'd6: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic bit special(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hffffffff));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, int e, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h", name, e, got, exp);
    end
  endtask

  // cycle-level model: an accepted op completes after XLEN+1 further edges, or at once for early-out cases
  initial begin
    for (int e = 0; e < 2; e++) begin
      act[e] = 0; left[e] = 0; out_r[e] = '0; out_d[e] = '0; pend_r[e] = '0; pend_d[e] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int e = 0; e < 2; e++) begin
        if (!rst_n) begin
          act[e] = 0; left[e] = 0; out_r[e] = '0; out_d[e] = '0;
        end else if (kill) begin
          act[e] = 0;
        end else if (start && (!act[e] || left[e] == 0)) begin
          act[e]    = 1;
          pend_r[e] = ref_fn(op, rs1, rs2);
          pend_d[e] = rd_in;
          left[e]   = (e == 1 && special(op, rs1, rs2)) ? 0 : 33;
          if (left[e] == 0) begin out_r[e] = pend_r[e]; out_d[e] = pend_d[e]; end
        end else if (act[e]) begin
          if (left[e] == 0) act[e] = 0;
          else begin
            left[e]--;
            if (left[e] == 0) begin out_r[e] = pend_r[e]; out_d[e] = pend_d[e]; end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int e = 0; e < 2; e++) begin
        chk("busy", e, 32'(busy_w[e]), 32'(act[e] && left[e] != 0));
        chk("done", e, 32'(done_w[e]), 32'(act[e] && left[e] == 0));
        chk("result", e, res_w[e], out_r[e]);
        chk("rd_out", e, 32'(rd_w[e]), 32'(out_d[e]));
      end
    end
  end

  task automatic set_op(logic [2:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] r);
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = r;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_w[0]) begin n = i; break; end
      #1 start = 1'b0;
    end
  endtask

  task automatic run_dir(string name, logic [2:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] r,
                         logic [31:0] exp, bit sp);
    int lat[2];
    lat = '{-1, -1};
    chk({"model_", name}, 0, ref_fn(o, a, b), exp);
    @(negedge clk);
    #1 set_op(o, a, b, r);
    for (int i = 0; i < 40 && (lat[0] < 0 || lat[1] < 0); i++) begin
      @(negedge clk);
      for (int e = 0; e < 2; e++)
        if (lat[e] < 0 && done_w[e]) begin
          lat[e] = i;
          chk({name, "_res"}, e, res_w[e], exp);
          chk({name, "_rd"}, e, 32'(rd_w[e]), 32'(r));
        end
      #1 start = 1'b0;
    end
    chk({name, "_lat"}, 0, 32'(lat[0]), 32'd33);
    chk({name, "_lat"}, 1, 32'(lat[1]), sp ? 32'd0 : 32'd33);
  endtask

  initial begin
    int n, dn;
    #1 rst_n = 1'b0;
    #2;
    for (int e = 0; e < 2; e++) begin
      chk("rst_busy", e, 32'(busy_w[e]), 32'd0);
      chk("rst_done", e, 32'(done_w[e]), 32'd0);
      chk("rst_result", e, res_w[e], 32'd0);
      chk("rst_rd", e, 32'(rd_w[e]), 32'd0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_dir("mul",    3'd0, 32'd7,        32'hfffffffd, 5'd9,  32'hffffffeb, 1'b0);
    run_dir("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0);
    run_dir("mulhu",  3'd3, 32'hffffffff, 32'hffffffff, 5'd2,  32'hfffffffe, 1'b0);
    run_dir("mulhsu", 3'd2, 32'hffffffff, 32'hffffffff, 5'd3,  32'hffffffff, 1'b0);
    run_dir("div",    3'd4, 32'hfffffff9, 32'd2,        5'd4,  32'hfffffffd, 1'b0);
    run_dir("rem",    3'd6, 32'hfffffff9, 32'd2,        5'd5,  32'hffffffff, 1'b0);
    run_dir("divu",   3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       1'b0);
    run_dir("divu0",  3'd5, 32'd7,        32'd0,        5'd8,  32'hffffffff, 1'b1);
    run_dir("rem0",   3'd6, 32'd7,        32'd0,        5'd10, 32'd7,        1'b1);
    run_dir("divovf", 3'd4, 32'h80000000, 32'hffffffff, 5'd11, 32'h80000000, 1'b1);
    run_dir("removf", 3'd6, 32'h80000000, 32'hffffffff, 5'd12, 32'd0,        1'b1);
    run_dir("remu",   3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        1'b0);

    // kill sampled at the edge ending the 10th CALC cycle
    @(negedge clk);
    #1 set_op(3'd0, 32'd1234, 32'd5678, 5'd13);
    dn = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 10) for (int e = 0; e < 2; e++) chk("kill_busy", e, 32'(busy_w[e]), 32'd0);
      for (int e = 0; e < 2; e++) if (done_w[e]) dn++;
      #1 start = 1'b0;
      kill = (i == 9);
    end
    chk("kill_no_done", 0, 32'(dn), 32'd0);
    for (int e = 0; e < 2; e++) chk("kill_res_held", e, res_w[e], 32'd2);
    run_dir("after_kill", 3'd0, 32'd6, 32'd7, 5'd14, 32'd42, 1'b0);

    // kill together with start, including an early-out candidate
    @(negedge clk);
    #1 set_op(3'd5, 32'd9, 32'd0, 5'd15);
    kill = 1'b1;
    @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      chk("killstart_busy", e, 32'(busy_w[e]), 32'd0);
      chk("killstart_done", e, 32'(done_w[e]), 32'd0);
    end
    #1 start = 1'b0; kill = 1'b0;

    // back-to-back: second start in the DONE cycle
    @(negedge clk);
    #1 set_op(3'd0, 32'd3, 32'd4, 5'd16);
    wait_done(n);
    chk("b2b_first_lat", 0, 32'(n), 32'd33);
    #1 set_op(3'd0, 32'd5, 32'd6, 5'd17);
    wait_done(n);
    chk("b2b_second_lat", 0, 32'(n), 32'd33);
    chk("b2b_second_res", 0, res_w[0], 32'd30);

    // a start during CALC is ignored
    @(negedge clk);
    @(negedge clk);
    #1 set_op(3'd0, 32'd9, 32'd9, 5'd18);
    @(negedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 set_op(3'd0, 32'd2, 32'd2, 5'd19);
    @(negedge clk);
    #1 start = 1'b0;
    wait_done(n);
    chk("calc_start_res", 0, res_w[0], 32'd81);
    chk("calc_start_rd", 0, 32'(rd_w[0]), 32'd18);

    // asynchronous reset mid-CALC
    @(negedge clk);
    @(negedge clk);
    #1 set_op(3'd7, 32'd1000, 32'd3, 5'd20);
    @(negedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int e = 0; e < 2; e++) begin
      chk("arst_busy", e, 32'(busy_w[e]), 32'd0);
      chk("arst_done", e, 32'(done_w[e]), 32'd0);
      chk("arst_result", e, res_w[e], 32'd0);
      chk("arst_rd", e, 32'(rd_w[e]), 32'd0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (3000) begin
      @(negedge clk);
      #1;
      start = ($urandom % 3) == 0;
      kill  = ($urandom % 30) == 0;
      op    = 3'($urandom);
      rs1   = pick();
      rs2   = pick();
      rd_in = 5'($urandom);
    end
    @(negedge clk);
    #1 start = 1'b0; kill = 1'b0;
    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
